// File: rtl/pp_mailbox_bridge.sv
// HPS<->fabric mailbox bridge: toggle-handshaked PIO command word drives
// per-channel TX/RX FWFT FIFOs; the result is returned on the PIO response word.
module pp_mbx_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_push,
  input  logic [W-1:0]  i_wdata,
  input  logic          i_pop,
  output logic [W-1:0]  o_head,
  output logic [AW:0]   o_count
);
  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0]   r_cnt;

  // Callers gate push on not-full and pop on not-empty.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (i_push) r_wptr <= r_wptr + AW'(1);
      if (i_pop)  r_rptr <= r_rptr + AW'(1);
      case ({i_push, i_pop})
        2'b10:   r_cnt <= r_cnt + (AW+1)'(1);
        2'b01:   r_cnt <= r_cnt - (AW+1)'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_push && !i_rst) r_mem[r_wptr] <= i_wdata;
  end

  assign o_head  = (r_cnt != '0) ? r_mem[r_rptr] : '0;
  assign o_count = r_cnt;
endmodule

module pp_mailbox_bridge #(
  parameter  int DATA_W = 32,
  parameter  int CH     = 4,
  parameter  int DEPTH  = 8,
  localparam int CH_W   = (CH == 1) ? 1 : $clog2(CH),
  localparam int PAY_W  = DATA_W - 2 - CH_W
) (
  input  logic                clk_clk,
  input  logic                reset_reset,
  input  logic [DATA_W-1:0]   pp_out_axi_export,
  output logic [DATA_W-1:0]   pp_in_axi_export,
  output logic [CH*PAY_W-1:0] tx_data,
  output logic [CH-1:0]       tx_valid,
  input  logic [CH-1:0]       tx_ready,
  input  logic [CH*PAY_W-1:0] rx_data,
  input  logic [CH-1:0]       rx_valid,
  output logic [CH-1:0]       rx_ready,
  output logic [CH-1:0]       rx_pending
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_ACK  = 2'd2;

  logic [DATA_W-1:0] r_cmd_q, r_resp;
  logic [1:0]        r_state;
  logic              r_last_tog, r_tog, r_op;
  logic [CH_W-1:0]   r_ch;
  logic [PAY_W-1:0]  r_pay, r_rdata;
  logic              r_err, r_rdv;

  logic [CH-1:0]            w_sel, w_tx_full, w_rx_full;
  logic [CH-1:0]            w_tx_push, w_tx_pop, w_rx_push, w_rx_pop;
  logic [CH-1:0][CW-1:0]    w_tx_cnt, w_rx_cnt;
  logic [CH-1:0][PAY_W-1:0] w_rx_head;
  logic                     w_exec, w_ch_ok, w_tx_full_sel, w_rx_empty_sel;
  logic                     w_err, w_rdv;
  logic [PAY_W-1:0]         w_rd;
  logic [DATA_W-1:0]        w_resp;

  assign w_exec = (r_state == S_EXEC);

  for (genvar c = 0; c < CH; c++) begin : g_ch
    assign w_sel[c]      = (r_ch == CH_W'(c));
    assign w_tx_full[c]  = (w_tx_cnt[c] == CW'(DEPTH));
    assign w_rx_full[c]  = (w_rx_cnt[c] == CW'(DEPTH));
    assign tx_valid[c]   = |w_tx_cnt[c];
    assign rx_pending[c] = |w_rx_cnt[c];
    assign rx_ready[c]   = ~w_rx_full[c];
    assign w_tx_push[c]  = w_exec & ~r_op & w_sel[c] & ~w_tx_full[c];
    assign w_tx_pop[c]   = tx_valid[c] & tx_ready[c];
    assign w_rx_push[c]  = rx_valid[c] & rx_ready[c];
    assign w_rx_pop[c]   = w_exec & r_op & w_sel[c] & rx_pending[c];

    pp_mbx_fifo #(.W(PAY_W), .DEPTH(DEPTH)) u_tx (
      .i_clk(clk_clk), .i_rst(reset_reset),
      .i_push(w_tx_push[c]), .i_wdata(r_pay), .i_pop(w_tx_pop[c]),
      .o_head(tx_data[c*PAY_W +: PAY_W]), .o_count(w_tx_cnt[c])
    );
    pp_mbx_fifo #(.W(PAY_W), .DEPTH(DEPTH)) u_rx (
      .i_clk(clk_clk), .i_rst(reset_reset),
      .i_push(w_rx_push[c]), .i_wdata(rx_data[c*PAY_W +: PAY_W]), .i_pop(w_rx_pop[c]),
      .o_head(w_rx_head[c]), .o_count(w_rx_cnt[c])
    );
  end

  // An out-of-range channel matches no select bit, so it gets err with no access.
  assign w_ch_ok        = |w_sel;
  assign w_tx_full_sel  = |(w_sel & w_tx_full);
  assign w_rx_empty_sel = |(w_sel & ~rx_pending);
  assign w_err          = ~w_ch_ok | (r_op ? w_rx_empty_sel : w_tx_full_sel);
  assign w_rdv          = w_ch_ok & r_op & ~w_rx_empty_sel;

  always_comb begin
    w_rd = '0;
    for (int c = 0; c < CH; c++)
      if (w_sel[c] && w_rdv) w_rd = w_rx_head[c];
  end

  always_comb begin
    w_resp              = '0;
    w_resp[DATA_W-1]    = r_tog;
    w_resp[DATA_W-2]    = r_err;
    w_resp[DATA_W-3]    = r_rdv;
    w_resp[PAY_W-1:0]   = r_rdata;
  end

  // Reset re-syncs last_tog to the live word so a stale tog starts nothing.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      r_cmd_q    <= pp_out_axi_export;
      r_last_tog <= pp_out_axi_export[DATA_W-1];
      r_resp     <= {pp_out_axi_export[DATA_W-1], {(DATA_W-1){1'b0}}};
      r_state    <= S_IDLE;
      r_tog      <= 1'b0;
      r_op       <= 1'b0;
      r_ch       <= '0;
      r_pay      <= '0;
      r_err      <= 1'b0;
      r_rdv      <= 1'b0;
      r_rdata    <= '0;
    end else begin
      r_cmd_q <= pp_out_axi_export;
      case (r_state)
        S_IDLE: if (r_cmd_q[DATA_W-1] != r_last_tog) begin
          r_tog   <= r_cmd_q[DATA_W-1];
          r_op    <= r_cmd_q[DATA_W-2];
          r_ch    <= r_cmd_q[DATA_W-3 -: CH_W];
          r_pay   <= r_cmd_q[PAY_W-1:0];
          r_state <= S_EXEC;
        end
        S_EXEC: begin
          r_err   <= w_err;
          r_rdv   <= w_rdv;
          r_rdata <= w_rd;
          r_state <= S_ACK;
        end
        S_ACK: begin
          r_resp     <= w_resp;
          r_last_tog <= r_tog;
          r_state    <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign pp_in_axi_export = r_resp;
endmodule

// File: tb/tb_pp_mailbox_bridge.sv
// Directed bench for pp_mailbox_bridge at default parameters (32b, 4 ch, depth 8).
module tb_pp_mailbox_bridge;
  logic         clk_clk = 1'b0;
  logic         reset_reset;
  logic [31:0]  pp_out, pp_in;
  logic [111:0] tx_data, rx_data;
  logic [3:0]   tx_valid, tx_ready, rx_valid, rx_ready, rx_pending;

  int   checks = 0;
  int   errors = 0;
  logic tog;

  pp_mailbox_bridge dut (
    .clk_clk(clk_clk), .reset_reset(reset_reset),
    .pp_out_axi_export(pp_out), .pp_in_axi_export(pp_in),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .rx_pending(rx_pending)
  );

  always #5 clk_clk = ~clk_clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  // Issue one command with a fresh tog; optionally pulse tx_ready / reset on the EXEC edge.
  // early = pp_in after 3 edges (must still be old), resp = pp_in after 4 edges.
  task automatic send(input logic op, input logic [1:0] ch, input logic [27:0] pay,
                      input logic [3:0] rdy_exec, input logic rst_exec,
                      output logic [31:0] early, output logic [31:0] resp);
    tog = ~tog;
    @(negedge clk_clk); pp_out = {tog, op, ch, pay};
    repeat (2) @(posedge clk_clk);
    @(negedge clk_clk); tx_ready = rdy_exec; reset_reset = rst_exec;
    @(posedge clk_clk);
    @(negedge clk_clk); tx_ready = 4'b0; early = pp_in;
    if (!rst_exec) begin
      @(posedge clk_clk);
      @(negedge clk_clk); resp = pp_in;
    end else resp = pp_in;
  endtask

  task automatic test_reset;
    pp_out = 32'h8000_0000; tx_ready = '0; rx_valid = '0; rx_data = '0;
    reset_reset = 1'b1;
    repeat (3) @(negedge clk_clk);
    checks++; if (pp_in !== 32'h8000_0000) begin errors++; $display("FAIL rst_ppin got %h exp %h", pp_in, 32'h8000_0000); end
    checks++; if ({tx_valid, rx_pending, rx_ready} !== 12'h00F) begin errors++; $display("FAIL rst_flags got %h exp %h", {tx_valid, rx_pending, rx_ready}, 12'h00F); end
    checks++; if (tx_data !== '0) begin errors++; $display("FAIL rst_txdata got %h exp 0", tx_data); end
    reset_reset = 1'b0; tog = 1'b1;
    repeat (6) @(negedge clk_clk);
    checks++; if (pp_in !== 32'h8000_0000) begin errors++; $display("FAIL post_rst_ppin got %h exp %h", pp_in, 32'h8000_0000); end
    checks++; if (tx_valid !== 4'b0) begin errors++; $display("FAIL post_rst_txvalid got %b exp 0000", tx_valid); end
  endtask

  task automatic test_read_empty;
    logic [31:0] e, r;
    send(1'b1, 2'd2, 28'h0, 4'b0, 1'b0, e, r);
    checks++; if (pp_out !== 32'h6000_0000) begin errors++; $display("FAIL rd_empty_cmd got %h exp %h", pp_out, 32'h6000_0000); end
    checks++; if (e !== 32'h8000_0000) begin errors++; $display("FAIL rd_empty_latency got %h exp %h", e, 32'h8000_0000); end
    checks++; if (r !== 32'h4000_0000) begin errors++; $display("FAIL rd_empty_resp got %h exp %h", r, 32'h4000_0000); end
  endtask

  task automatic test_write;
    logic [31:0] e, r;
    send(1'b0, 2'd1, 28'hABC, 4'b0, 1'b0, e, r);
    checks++; if (e !== 32'h4000_0000) begin errors++; $display("FAIL wr_latency got %h exp %h", e, 32'h4000_0000); end
    checks++; if (r !== 32'h8000_0000) begin errors++; $display("FAIL wr_resp got %h exp %h", r, 32'h8000_0000); end
    checks++; if (tx_valid !== 4'b0010) begin errors++; $display("FAIL wr_txvalid got %b exp 0010", tx_valid); end
    checks++; if (tx_data[55:28] !== 28'h0000ABC) begin errors++; $display("FAIL wr_txdata got %h exp %h", tx_data[55:28], 28'hABC); end
    tx_ready = 4'b0010;
    @(negedge clk_clk); tx_ready = 4'b0;
    checks++; if (tx_valid !== 4'b0000) begin errors++; $display("FAIL wr_pop got %b exp 0000", tx_valid); end
  endtask

  task automatic test_no_new_tog;
    // non-tog bits change, tog unchanged: no command
    @(negedge clk_clk); pp_out = {tog, 31'h3000_0123};
    repeat (6) @(negedge clk_clk);
    checks++; if (pp_in !== 32'h8000_0000 || tx_valid !== 4'b0) begin errors++; $display("FAIL same_tog got %h/%b exp %h/0000", pp_in, tx_valid, 32'h8000_0000); end
  endtask

  task automatic test_read_data;
    logic [31:0] e, r;
    send(1'b1, 2'd2, 28'h0, 4'b0, 1'b0, e, r);
    checks++; if (r !== 32'h4000_0000) begin errors++; $display("FAIL rd2_resp got %h exp %h", r, 32'h4000_0000); end
    @(negedge clk_clk); rx_data[84 +: 28] = 28'h1234567; rx_valid = 4'b1000;
    @(negedge clk_clk); rx_valid = 4'b0;
    checks++; if (rx_pending !== 4'b1000) begin errors++; $display("FAIL rx_pending got %b exp 1000", rx_pending); end
    send(1'b1, 2'd3, 28'h0, 4'b0, 1'b0, e, r);
    checks++; if (pp_out !== 32'hF000_0000) begin errors++; $display("FAIL rd_cmd got %h exp %h", pp_out, 32'hF000_0000); end
    checks++; if (r !== 32'hA123_4567) begin errors++; $display("FAIL rd_resp got %h exp %h", r, 32'hA123_4567); end
    checks++; if (rx_pending !== 4'b0000) begin errors++; $display("FAIL rd_pending got %b exp 0000", rx_pending); end
  endtask

  task automatic test_full;
    logic [31:0] e, r;
    int n;
    for (int i = 0; i < 8; i++) begin
      send(1'b0, 2'd0, 28'(i), 4'b0, 1'b0, e, r);
      checks++; if (r !== {tog, 31'b0}) begin errors++; $display("FAIL fill_%0d got %h exp %h", i, r, {tog, 31'b0}); end
    end
    send(1'b0, 2'd0, 28'd8, 4'b0, 1'b0, e, r);
    checks++; if (r !== {tog, 1'b1, 30'b0}) begin errors++; $display("FAIL full_ninth got %h exp %h", r, {tog, 1'b1, 30'b0}); end
    send(1'b0, 2'd0, 28'd9, 4'b0001, 1'b0, e, r);
    checks++; if (r !== {tog, 1'b1, 30'b0}) begin errors++; $display("FAIL full_tenth got %h exp %h", r, {tog, 1'b1, 30'b0}); end
    checks++; if (tx_valid !== 4'b0001) begin errors++; $display("FAIL full_indep got %b exp 0001", tx_valid); end
    // drain: remaining words are 1..7 in order
    tx_ready = 4'b0001; n = 0;
    for (int i = 0; i < 20 && tx_valid[0]; i++) begin
      checks++; if (tx_data[27:0] !== 28'(n + 1)) begin errors++; $display("FAIL drain_%0d got %h exp %h", n, tx_data[27:0], 28'(n + 1)); end
      n++;
      @(posedge clk_clk); @(negedge clk_clk);
    end
    tx_ready = 4'b0;
    checks++; if (n !== 7) begin errors++; $display("FAIL drain_count got %0d exp 7", n); end
  endtask

  task automatic test_reset_abort;
    logic [31:0] e, r;
    logic [31:0] exp_in;
    send(1'b0, 2'd2, 28'h55, 4'b0, 1'b1, e, r);
    exp_in = {pp_out[31], 31'b0};
    checks++; if (tx_valid !== 4'b0 || pp_in !== exp_in) begin errors++; $display("FAIL abort got %b/%h exp 0000/%h", tx_valid, pp_in, exp_in); end
    reset_reset = 1'b0;
    repeat (6) @(negedge clk_clk);
    checks++; if (tx_valid !== 4'b0 || pp_in !== exp_in) begin errors++; $display("FAIL abort_after got %b/%h exp 0000/%h", tx_valid, pp_in, exp_in); end
  endtask

  initial begin
    test_reset();
    test_read_empty();
    test_write();
    test_no_new_tog();
    test_read_data();
    test_full();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
